// File: rtl/tx_relatorio_peso_8n1.sv
// 8N1 serial transmitter that reports one weighing result: two ASCII digits, status letter, '#'.
// Define TX_RELATORIO_CRLF_EN to append CR LF after the terminator.
//
// state   | meaning
// OCIOSO  | idle, line high, waiting for partida
// INICIO  | start bit (line low)
// DADOS   | 8 data bits, LSB first
// PARADA  | stop bit; last cycle also makes the PROXIMO decision
// PROXIMO | next-byte decision, folded into the last PARADA cycle (never occupied)
// FIM     | one cycle with pronto high, then back to OCIOSO
module tx_relatorio_peso_8n1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [15:0] peso_atual,
  input  logic        pertence,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef TX_RELATORIO_CRLF_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARADA, PROXIMO, FIM} stateType;

  stateType          state;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitIdx;
  logic [2:0]        byteIdx;
  logic [15:0]       pesoReg;
  logic              pertenceReg;
  logic [7:0]        curByte;
  logic              baudDone;

  function automatic logic [7:0] digitAscii(input logic [7:0] digit);
    return (digit > 8'd9) ? 8'h3F : (8'h30 + digit);
  endfunction

  // Byte contents come only from the latched copies, so inputs may change mid-frame.
  always_comb begin
    curByte = 8'h23;
    case (byteIdx)
      3'd0: curByte = digitAscii(pesoReg[15:8]);
      3'd1: curByte = digitAscii(pesoReg[7:0]);
      3'd2: curByte = pertenceReg ? 8'h41 : 8'h52;
      3'd3: curByte = 8'h23;
`ifdef TX_RELATORIO_CRLF_EN
      3'd4: curByte = 8'h0D;
      3'd5: curByte = 8'h0A;
`endif
      default: curByte = 8'h23;
    endcase
  end

  assign baudDone = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= OCIOSO;
      baudCnt      <= '0;
      bitIdx       <= '0;
      byteIdx      <= '0;
      pesoReg      <= '0;
      pertenceReg  <= 1'b0;
      saida_serial <= 1'b1;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          saida_serial <= 1'b1;
          ocupado      <= 1'b0;
          if (partida) begin
            pesoReg      <= peso_atual;
            pertenceReg  <= pertence;
            baudCnt      <= '0;
            bitIdx       <= '0;
            byteIdx      <= '0;
            saida_serial <= 1'b0;
            ocupado      <= 1'b1;
            state        <= INICIO;
          end
        end
        INICIO: begin
          if (baudDone) begin
            baudCnt      <= '0;
            bitIdx       <= '0;
            saida_serial <= curByte[0];
            state        <= DADOS;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        DADOS: begin
          if (baudDone) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              saida_serial <= 1'b1;
              state        <= PARADA;
            end else begin
              bitIdx       <= bitIdx + 3'd1;
              saida_serial <= curByte[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        PARADA: begin
          if (baudDone) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            // Next start bit follows the stop bit directly, no idle gap.
            if (byteIdx < LAST_BYTE) begin
              byteIdx      <= byteIdx + 3'd1;
              saida_serial <= 1'b0;
              state        <= INICIO;
            end else begin
              saida_serial <= 1'b1;
              ocupado      <= 1'b0;
              pronto       <= 1'b1;
              state        <= FIM;
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        FIM: begin
          saida_serial <= 1'b1;
          ocupado      <= 1'b0;
          state        <= OCIOSO;
        end
        default: begin
          saida_serial <= 1'b1;
          ocupado      <= 1'b0;
          state        <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_relatorio_peso_8n1.sv
// Directed bench for tx_relatorio_peso_8n1 at CLKS_PER_BIT=4: decodes the serial line
// from a per-cycle log and checks bytes, framing bits, ocupado/pronto timing and reset.
module tb_tx_relatorio_peso_8n1;

  localparam int CPB = 4;
`ifdef TX_RELATORIO_CRLF_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 4;
`endif
  localparam int FRAME = NBYTES * 10 * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        partida = 1'b0;
  logic [15:0] peso_atual = 16'h0000;
  logic        pertence = 1'b0;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;

  int nCompared = 0;
  int nMismatched = 0;

  logic lineLog [0:399];
  logic ocupLog [0:399];
  logic prontoLog [0:399];

  tx_relatorio_peso_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .partida     (partida),
    .peso_atual  (peso_atual),
    .pertence    (pertence),
    .saida_serial(saida_serial),
    .ocupado     (ocupado),
    .pronto      (pronto)
  );

  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Cycle 0 = partida driven; cycle n = interval after the n-th following edge.
  task automatic runFrame(input logic [15:0] peso, input logic pert, input int changeAt,
                          input int againAt, input int resetAt, input bit hold, input int nCycles);
    peso_atual = peso;
    pertence   = pert;
    partida    = 1'b1;
    for (int n = 1; n <= nCycles; n++) begin
      step();
      lineLog[n]   = saida_serial;
      ocupLog[n]   = ocupado;
      prontoLog[n] = pronto;
      partida = hold || (n == againAt);
      reset   = (n == resetAt);
      if (n == changeAt) begin
        peso_atual = 16'h0000;
        pertence   = ~pert;
      end
    end
    partida = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic checkFrame(input string name, input logic [47:0] exp, input int nBytes);
    for (int b = 0; b < nBytes; b++) begin
      int s;
      logic [7:0] v;
      s = b * 10 * CPB + 1;
      for (int k = 0; k < 8; k++) v[k] = lineLog[s + CPB * (k + 1) + 1];
      checkEq($sformatf("%s start%0d", name, b), 32'(lineLog[s + 1]), 32'd0);
      checkEq($sformatf("%s byte%0d", name, b), 32'(v), 32'(exp[8*b +: 8]));
      checkEq($sformatf("%s stop%0d", name, b), 32'(lineLog[s + 9 * CPB + 1]), 32'd1);
    end
  endtask

  task automatic checkPronto(input string name, input int nCycles, input int expCount, input int expAt);
    int cnt;
    int firstAt;
    cnt = 0;
    firstAt = -1;
    for (int n = 1; n <= nCycles; n++) begin
      if (prontoLog[n] === 1'b1) begin
        cnt++;
        if (firstAt < 0) firstAt = n;
      end
    end
    checkEq({name, " pronto count"}, 32'(cnt), 32'(expCount));
    if (expCount > 0) checkEq({name, " pronto cycle"}, 32'(firstAt), 32'(expAt));
  endtask

  initial begin
    int highs;
    int busy;

    // Reset held 3 cycles then released
    repeat (3) step();
    reset = 1'b0;
    step();
    checkEq("rst line", 32'(saida_serial), 32'd1);
    checkEq("rst ocupado", 32'(ocupado), 32'd0);
    checkEq("rst pronto", 32'(pronto), 32'd0);
    highs = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (saida_serial === 1'b1 && ocupado === 1'b0) highs++;
    end
    checkEq("idle line", 32'(highs), 32'd50);

    // Reset and partida together: reset wins
    reset = 1'b1;
    partida = 1'b1;
    step();
    checkEq("rst+partida ocupado", 32'(ocupado), 32'd0);
    checkEq("rst+partida line", 32'(saida_serial), 32'd1);
    reset = 1'b0;
    partida = 1'b0;
    step();
    checkEq("rst+partida after", 32'(ocupado), 32'd0);

    // 0307, in range
    runFrame(16'h0307, 1'b1, -1, -1, -1, 1'b0, FRAME + 4);
    checkFrame("f0307", {16'h0A0D, 32'h23413733}, NBYTES);
    checkPronto("f0307", FRAME + 4, 1, FRAME + 1);
    checkEq("f0307 ocupado first", 32'(ocupLog[1]), 32'd1);
    checkEq("f0307 ocupado last", 32'(ocupLog[FRAME]), 32'd1);
    checkEq("f0307 ocupado end", 32'(ocupLog[FRAME + 1]), 32'd0);
    checkEq("f0307 line fim", 32'(lineLog[FRAME + 1]), 32'd1);
    busy = 0;
    for (int n = 1; n <= FRAME + 4; n++) if (ocupLog[n] === 1'b1) busy++;
    checkEq("f0307 ocupado cycles", 32'(busy), 32'(FRAME));

    // 0902, out of range, inputs changed at cycle 20
    runFrame(16'h0902, 1'b0, 20, -1, -1, 1'b0, FRAME + 4);
    checkFrame("f0902", {16'h0A0D, 32'h23523239}, NBYTES);
    checkPronto("f0902", FRAME + 4, 1, FRAME + 1);

    // Tens digit out of range
    runFrame(16'h0C05, 1'b1, -1, -1, -1, 1'b0, FRAME + 4);
    checkFrame("f0C05", {16'h0A0D, 32'h2341353F}, NBYTES);

    // Second partida mid-frame is ignored
    runFrame(16'h0307, 1'b1, -1, 50, -1, 1'b0, FRAME + 40);
    checkPronto("again", FRAME + 40, 1, FRAME + 1);
    checkEq("again idle", 32'(ocupLog[FRAME + 3]), 32'd0);

    // Reset mid-frame at cycle 70
    runFrame(16'h0307, 1'b1, -1, -1, 70, 1'b0, FRAME + 10);
    checkEq("midrst line", 32'(lineLog[71]), 32'd1);
    checkEq("midrst ocupado", 32'(ocupLog[71]), 32'd0);
    checkEq("midrst ocupado later", 32'(ocupLog[80]), 32'd0);
    checkPronto("midrst", FRAME + 10, 0, 0);

    // partida held high: next frame begins frame_length+2 cycles later
    runFrame(16'h0307, 1'b1, -1, -1, -1, 1'b1, FRAME + 4);
    checkEq("held pronto", 32'(prontoLog[FRAME + 1]), 32'd1);
    checkEq("held gap ocupado", 32'(ocupLog[FRAME + 2]), 32'd0);
    checkEq("held gap line", 32'(lineLog[FRAME + 2]), 32'd1);
    checkEq("held restart ocupado", 32'(ocupLog[FRAME + 3]), 32'd1);
    checkEq("held restart line", 32'(lineLog[FRAME + 3]), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // 0104, in range (CR LF appended when enabled)
    runFrame(16'h0104, 1'b1, -1, -1, -1, 1'b0, FRAME + 4);
    checkFrame("f0104", {16'h0A0D, 32'h23413431}, NBYTES);
    checkPronto("f0104", FRAME + 4, 1, FRAME + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
